// File: rtl/block_id_loader.sv
// Block ID loader: reads the per-block ID bytes from a small synchronous memory,
// validates an optional trailing XOR checksum, publishes the ID as a stable
// register and announces it once as a single-beat streaming word.
module block_id_loader #(
   parameter int unsigned NUM_ID_BYTES = 4,
   parameter int unsigned ADDR_WIDTH   = 5,
   parameter int unsigned BASE_ADDR    = 0,
   parameter int unsigned CHECK_EN     = 1,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   output logic [ADDR_WIDTH-1:0]     mem_address,
   output logic                      mem_chipselect,
   output logic                      mem_clken,
   output logic                      mem_write,
   input  logic [7:0]                mem_readdata,
   input  logic                      reload,
   output logic [8*NUM_ID_BYTES-1:0] block_id,
   output logic                      id_valid,
   output logic                      id_error,
   output logic                      busy,
   output logic [8*NUM_ID_BYTES-1:0] src_data,
   output logic                      src_valid,
   input  logic                      src_ready
);

   localparam int unsigned IdW = 8 * NUM_ID_BYTES;
   // Index of the last memory read: the checksum byte when checking is enabled.
   localparam logic [3:0] LastIdx = 4'(NUM_ID_BYTES + CHECK_EN - 1);
   localparam logic [3:0] NumIdx  = 4'(NUM_ID_BYTES);
   localparam logic [1:0] LatInit = 2'(READ_LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StWait,
      StAnnounce,
      StDone
   } state_e;

   state_e         state_q, state_d;
   logic [3:0]     idx_q, idx_d;
   logic [1:0]     lat_q, lat_d;
   logic [7:0]     acc_q, acc_d;
   logic [IdW-1:0] shadow_q, shadow_d;
   logic [IdW-1:0] block_id_q, block_id_d;
   logic [IdW-1:0] src_data_q, src_data_d;
   logic           id_valid_q, id_valid_d;
   logic           id_error_q, id_error_d;
   logic           chk_ok;

   // State and datapath registers; reset aborts any load or announce in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         lat_q      <= '0;
         acc_q      <= '0;
         shadow_q   <= '0;
         block_id_q <= '0;
         src_data_q <= '0;
         id_valid_q <= 1'b0;
         id_error_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         lat_q      <= lat_d;
         acc_q      <= acc_d;
         shadow_q   <= shadow_d;
         block_id_q <= block_id_d;
         src_data_q <= src_data_d;
         id_valid_q <= id_valid_d;
         id_error_q <= id_error_d;
      end
   end

   // Next-state logic: byte walk, checksum check, commit and announce handshake.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      lat_d      = lat_q;
      acc_d      = acc_q;
      shadow_d   = shadow_q;
      block_id_d = block_id_q;
      src_data_d = src_data_q;
      id_valid_d = id_valid_q;
      id_error_d = id_error_q;
      // Only meaningful on the checksum read; vacuously true with checking off.
      chk_ok     = (CHECK_EN == 0) || (mem_readdata == acc_q);

      case (state_q)
         StIdle: begin
            idx_d   = '0;
            acc_d   = '0;
            state_d = StRead;
         end
         StRead: begin
            lat_d   = LatInit;
            state_d = StWait;
         end
         StWait: begin
            if (lat_q != 2'd0) begin
               lat_d = lat_q - 2'd1;
            end else begin
               if (idx_q < NumIdx) begin
                  for (int unsigned i = 0; i < NUM_ID_BYTES; i++) begin
                     if (idx_q == 4'(i)) begin
                        shadow_d[8*i +: 8] = mem_readdata;
                     end
                  end
                  acc_d = acc_q ^ mem_readdata;
               end
               if (idx_q == LastIdx) begin
                  if (chk_ok) begin
                     // shadow_d already holds the final data byte when checking is off.
                     block_id_d = shadow_d;
                     src_data_d = shadow_d;
                     id_valid_d = 1'b1;
                     id_error_d = 1'b0;
                     state_d    = StAnnounce;
                  end else begin
                     id_valid_d = 1'b0;
                     id_error_d = 1'b1;
                     state_d    = StDone;
                  end
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = StRead;
               end
            end
         end
         StAnnounce: begin
            if (src_ready) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (reload) begin
               id_valid_d = 1'b0;
               id_error_d = 1'b0;
               idx_d      = '0;
               acc_d      = '0;
               state_d    = StRead;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from state and registers; memory is only touched while reading.
   always_comb begin
      mem_address    = BaseAddr + ADDR_WIDTH'(idx_q);
      mem_chipselect = (state_q == StRead) || (state_q == StWait);
      mem_clken      = mem_chipselect;
      mem_write      = 1'b0;
      busy           = (state_q == StRead) || (state_q == StWait) || (state_q == StAnnounce);
      src_valid      = (state_q == StAnnounce);
      block_id       = block_id_q;
      src_data       = src_data_q;
      id_valid       = id_valid_q;
      id_error       = id_error_q;
   end

endmodule

// File: tb/tb_block_id_loader.sv
// Directed bench for block_id_loader: default configuration plus a
// latency-3 / no-checksum / offset-base instance, each with a memory model.
module tb_block_id_loader;

   logic clk;
   logic rst_a_n, rst_b_n;

   // Instance A: defaults
   logic [4:0]  a_addr;
   logic        a_cs, a_clken, a_wr, a_reload, a_id_valid, a_id_error, a_busy;
   logic        a_src_valid, a_src_ready;
   logic [7:0]  a_rdata;
   logic [31:0] a_block_id, a_src_data;

   // Instance B: READ_LATENCY=3, CHECK_EN=0, BASE_ADDR=8
   logic [4:0]  b_addr;
   logic        b_cs, b_clken, b_wr, b_reload, b_id_valid, b_id_error, b_busy;
   logic        b_src_valid, b_src_ready;
   logic [7:0]  b_rdata;
   logic [31:0] b_block_id, b_src_data;

   logic [7:0] mem_a [32];
   logic [7:0] mem_b [32];
   logic [4:0] a_addr_q, b_addr_q;
   logic [7:0] b_d1, b_d2;

   int n_checks = 0;
   int n_pass   = 0;
   int a_xfer   = 0;
   int b_bad_rd = 0;

   block_id_loader u_dut_a (
      .clk            (clk),
      .reset_n        (rst_a_n),
      .mem_address    (a_addr),
      .mem_chipselect (a_cs),
      .mem_clken      (a_clken),
      .mem_write      (a_wr),
      .mem_readdata   (a_rdata),
      .reload         (a_reload),
      .block_id       (a_block_id),
      .id_valid       (a_id_valid),
      .id_error       (a_id_error),
      .busy           (a_busy),
      .src_data       (a_src_data),
      .src_valid      (a_src_valid),
      .src_ready      (a_src_ready)
   );

   block_id_loader #(
      .NUM_ID_BYTES (4),
      .ADDR_WIDTH   (5),
      .BASE_ADDR    (8),
      .CHECK_EN     (0),
      .READ_LATENCY (3)
   ) u_dut_b (
      .clk            (clk),
      .reset_n        (rst_b_n),
      .mem_address    (b_addr),
      .mem_chipselect (b_cs),
      .mem_clken      (b_clken),
      .mem_write      (b_wr),
      .mem_readdata   (b_rdata),
      .reload         (b_reload),
      .block_id       (b_block_id),
      .id_valid       (b_id_valid),
      .id_error       (b_id_error),
      .busy           (b_busy),
      .src_data       (b_src_data),
      .src_valid      (b_src_valid),
      .src_ready      (b_src_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory A: registered address, unregistered q (latency 1)
   always @(posedge clk) if (a_clken) a_addr_q <= a_addr;
   assign a_rdata = mem_a[a_addr_q];

   // Memory B: registered address plus two output stages (latency 3)
   always @(posedge clk) begin
      if (b_clken) begin
         b_addr_q <= b_addr;
         b_d1     <= mem_b[b_addr_q];
         b_d2     <= b_d1;
      end
   end
   assign b_rdata = b_d2;

   always @(posedge clk) begin
      if (a_src_valid && a_src_ready) a_xfer <= a_xfer + 1;
      if (b_cs && (b_addr == 5'd12)) b_bad_rd <= b_bad_rd + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic load_good_a();
      mem_a[0] = 8'h12; mem_a[1] = 8'h34; mem_a[2] = 8'h56; mem_a[3] = 8'h78;
      mem_a[4] = 8'h08;
   endtask

   initial begin
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      a_reload = 1'b0; b_reload = 1'b0;
      a_src_ready = 1'b0; b_src_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'hff;
      end
      load_good_a();
      mem_b[8] = 8'h01; mem_b[9] = 8'h02; mem_b[10] = 8'h03; mem_b[11] = 8'h04;
      mem_b[12] = 8'h5a;
      tick(); tick();

      // Reset state
      check("rst_id_valid", 64'(a_id_valid), 64'(0));
      check("rst_id_error", 64'(a_id_error), 64'(0));
      check("rst_busy", 64'(a_busy), 64'(0));
      check("rst_cs", 64'(a_cs), 64'(0));
      check("rst_clken", 64'(a_clken), 64'(0));
      check("rst_addr", 64'(a_addr), 64'(0));
      check("rst_block_id", 64'(a_block_id), 64'(0));
      check("rst_src_valid", 64'(a_src_valid), 64'(0));
      check("rst_src_data", 64'(a_src_data), 64'(0));
      check("rst_mem_write", 64'(a_wr), 64'(0));
      check("rst_b_addr", 64'(b_addr), 64'(8));

      // Instance B: addresses 8..11, 4 cycles each, valid at edge 17
      rst_b_n = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (k <= 16) begin
            check("b_addr", 64'(b_addr), 64'(8 + (k - 1) / 4));
            check("b_cs", 64'(b_cs), 64'(1));
         end
         if (k == 16) check("b_valid_early", 64'(b_id_valid), 64'(0));
      end
      check("b_valid", 64'(b_id_valid), 64'(1));
      check("b_block_id", 64'(b_block_id), 64'(32'h04030201));
      tick(); tick(); tick();
      check("b_no_addr12", 64'(b_bad_rd), 64'(0));
      check("b_idle_cs", 64'(b_cs), 64'(0));
      check("b_idle_busy", 64'(b_busy), 64'(0));

      // Instance A: good load, 2 cycles per address, valid at edge 11
      rst_a_n = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         if (k <= 10) begin
            check("a_addr", 64'(a_addr), 64'((k - 1) / 2));
            check("a_cs", 64'(a_cs), 64'(1));
         end
         if (k == 10) check("a_valid_early", 64'(a_id_valid), 64'(0));
      end
      check("a_valid", 64'(a_id_valid), 64'(1));
      check("a_error", 64'(a_id_error), 64'(0));
      check("a_block_id", 64'(a_block_id), 64'(32'h78563412));
      check("a_src_valid", 64'(a_src_valid), 64'(1));
      check("a_src_data", 64'(a_src_data), 64'(32'h78563412));
      check("a_busy_ann", 64'(a_busy), 64'(1));

      // Backpressure for 5 cycles, with a reload pulse that must be ignored
      for (int k = 1; k <= 5; k++) begin
         if (k == 2) a_reload = 1'b1;
         tick();
         a_reload = 1'b0;
         check("bp_src_valid", 64'(a_src_valid), 64'(1));
         check("bp_src_data", 64'(a_src_data), 64'(32'h78563412));
         check("bp_cs", 64'(a_cs), 64'(0));
      end
      a_src_ready = 1'b1;
      tick();
      a_src_ready = 1'b0;
      check("xfer_src_valid", 64'(a_src_valid), 64'(0));
      check("xfer_busy", 64'(a_busy), 64'(0));
      check("xfer_count", 64'(a_xfer), 64'(1));
      tick(); tick(); tick();
      check("xfer_once", 64'(a_xfer), 64'(1));
      check("done_cs", 64'(a_cs), 64'(0));

      // Reload with new contents; a reload pulse in WAIT must not restart
      mem_a[0] = 8'haa; mem_a[1] = 8'hbb; mem_a[2] = 8'hcc; mem_a[3] = 8'hdd;
      mem_a[4] = 8'h00;
      a_reload = 1'b1;
      tick();
      a_reload = 1'b0;
      check("rl_valid_drop", 64'(a_id_valid), 64'(0));
      check("rl_block_id_kept", 64'(a_block_id), 64'(32'h78563412));
      check("rl_addr0", 64'(a_addr), 64'(0));
      check("rl_busy", 64'(a_busy), 64'(1));
      for (int k = 1; k <= 10; k++) begin
         if (k == 2) a_reload = 1'b1;
         tick();
         a_reload = 1'b0;
         if (k <= 9) check("rl_addr", 64'(a_addr), 64'(k / 2));
         if (k == 9) check("rl_valid_early", 64'(a_id_valid), 64'(0));
      end
      check("rl_valid", 64'(a_id_valid), 64'(1));
      check("rl_block_id", 64'(a_block_id), 64'(32'hddccbbaa));
      check("rl_src_valid", 64'(a_src_valid), 64'(1));
      check("rl_src_data", 64'(a_src_data), 64'(32'hddccbbaa));
      a_src_ready = 1'b1;
      tick();
      a_src_ready = 1'b0;
      check("rl_xfer", 64'(a_xfer), 64'(2));

      // Reset during WAIT of byte 2, then a full clean load
      load_good_a();
      a_reload = 1'b1;
      tick();
      a_reload = 1'b0;
      for (int k = 1; k <= 5; k++) tick();
      check("mid_addr", 64'(a_addr), 64'(2));
      check("mid_cs", 64'(a_cs), 64'(1));
      #2 rst_a_n = 1'b0;
      #1;
      check("arst_busy", 64'(a_busy), 64'(0));
      check("arst_cs", 64'(a_cs), 64'(0));
      check("arst_clken", 64'(a_clken), 64'(0));
      check("arst_addr", 64'(a_addr), 64'(0));
      check("arst_block_id", 64'(a_block_id), 64'(0));
      check("arst_valid", 64'(a_id_valid), 64'(0));
      check("arst_src_valid", 64'(a_src_valid), 64'(0));
      tick();
      rst_a_n = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         if (k == 10) check("re_valid_early", 64'(a_id_valid), 64'(0));
      end
      check("re_valid", 64'(a_id_valid), 64'(1));
      check("re_block_id", 64'(a_block_id), 64'(32'h78563412));
      a_src_ready = 1'b1;
      tick();
      a_src_ready = 1'b0;
      check("re_xfer", 64'(a_xfer), 64'(3));

      // Bad checksum from reset: error, no commit, no announce
      rst_a_n = 1'b0;
      mem_a[4] = 8'h09;
      tick(); tick();
      rst_a_n = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         check("bad_src_valid", 64'(a_src_valid), 64'(0));
      end
      check("bad_error", 64'(a_id_error), 64'(1));
      check("bad_valid", 64'(a_id_valid), 64'(0));
      check("bad_block_id", 64'(a_block_id), 64'(0));
      check("bad_busy", 64'(a_busy), 64'(0));
      tick(); tick(); tick();
      check("bad_no_ann", 64'(a_src_valid), 64'(0));
      check("bad_xfer", 64'(a_xfer), 64'(3));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
